// File: rtl/mult_cell_sched_pkg.sv
// mult_cell_sched_pkg: shared state encoding, half-word width and partial-product combiner
package mult_cell_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      SUM  = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam int HW = 16;

   // low 32 bits of A*B from the three 16x16 partials; the high*high term never reaches bit 31
   function automatic logic [31:0] combine_pp(input logic [31:0] p1, input logic [31:0] p2,
                                              input logic [31:0] p3);
      return p1 + ((p2 + p3) << HW);
   endfunction

endpackage

// File: rtl/mult_cell_sched_if.sv
// mult_cell_sched_if: two request channels and one tagged response channel
interface mult_cell_sched_if #(parameter int W = 32);

   logic         req0_valid;
   logic         req0_ready;
   logic [W-1:0] req0_a;
   logic [W-1:0] req0_b;
   logic         req1_valid;
   logic         req1_ready;
   logic [W-1:0] req1_a;
   logic [W-1:0] req1_b;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_data;
   logic         rsp_id;

   modport master (
      output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
      input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
      output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
   );

endinterface

// File: rtl/mult_cell_rr_arb.sv
// mult_cell_rr_arb: 2-way round-robin arbiter, pointer moves past the winner on each grant
module mult_cell_rr_arb (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] valid_i,
   input  logic       en_i,
   output logic [1:0] ready_o,
   output logic       gnt_id_o
);

   logic rr_ptr_q, rr_ptr_d;
   logic accept;

   assign gnt_id_o = &valid_i ? rr_ptr_q : valid_i[1];
   assign accept   = en_i && |valid_i;
   assign ready_o  = accept ? (gnt_id_o ? 2'b10 : 2'b01) : 2'b00;
   assign rr_ptr_d = accept ? ~gnt_id_o : rr_ptr_q;

   // priority pointer, requester 0 first out of reset
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) rr_ptr_q <= 1'b0;
      else          rr_ptr_q <= rr_ptr_d;

endmodule

// File: rtl/mult_cell_sched.sv
// mult_cell_sched: shares one 16x16 partial-product multiplier cell between two requesters
module mult_cell_sched
   import mult_cell_sched_pkg::*;
#(
   parameter int CELL_LAT = 1,
   parameter int W        = 32
) (
   input  logic          clk,
   input  logic          reset_n,
   mult_cell_sched_if.slave bus,
   output logic [W-1:0]  cell_src1,
   output logic [W-1:0]  cell_src2,
   output logic          cell_en,
   input  logic [W-1:0]  cell_p1,
   input  logic [W-1:0]  cell_p2,
   input  logic [W-1:0]  cell_p3,
   output logic          busy
);

   localparam logic [2:0] LAT_LAST = 3'(CELL_LAT - 1);

   state_t       state_q, state_d;
   logic [2:0]   lat_cnt_q, lat_cnt_d;
   logic [W-1:0] src1_q, src2_q, rsp_data_q;
   logic         id_q;
   logic [1:0]   ready;
   logic         gnt_id;
   logic         accept;

   mult_cell_rr_arb u_arb (
      .clk      (clk),
      .reset_n  (reset_n),
      .valid_i  ({bus.req1_valid, bus.req0_valid}),
      .en_i     (state_q == IDLE),
      .ready_o  (ready),
      .gnt_id_o (gnt_id)
   );

   assign accept         = |ready;
   assign bus.req0_ready = ready[0];
   assign bus.req1_ready = ready[1];
   assign bus.rsp_valid  = state_q == RESP;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.rsp_id     = id_q;
   assign cell_src1      = src1_q;
   assign cell_src2      = src2_q;
   assign cell_en        = state_q == MUL;
   assign busy           = state_q != IDLE;

   // state and cell-latency counter registers
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q   <= IDLE;
         lat_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         lat_cnt_q <= lat_cnt_d;
      end

   // sequencing: accept, hold cell_en for CELL_LAT cycles, sum partials, wait for consumer
   always_comb begin
      state_d   = state_q;
      lat_cnt_d = lat_cnt_q;
      unique case (state_q)
         IDLE: state_d = accept ? MUL : IDLE;
         MUL: begin
            state_d   = (lat_cnt_q == LAT_LAST) ? SUM : MUL;
            lat_cnt_d = (lat_cnt_q == LAT_LAST) ? 3'd0 : lat_cnt_q + 3'd1;
         end
         SUM:  state_d = RESP;
         RESP: state_d = bus.rsp_ready ? IDLE : RESP;
      endcase
   end

   // operand/ID capture on accept and result capture once the partials are valid
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         src1_q     <= '0;
         src2_q     <= '0;
         id_q       <= 1'b0;
         rsp_data_q <= '0;
      end else begin
         if (accept) begin
            src1_q <= gnt_id ? bus.req1_a : bus.req0_a;
            src2_q <= gnt_id ? bus.req1_b : bus.req0_b;
            id_q   <= gnt_id;
         end
         if (state_q == SUM) rsp_data_q <= combine_pp(cell_p1, cell_p2, cell_p3);
      end

endmodule

// File: doc/mult_cell_sched.md
Name: mult_cell_sched

Overview:
- Sequences and shares the Nios CPU's 16x16 triple-partial-product multiplier cell between two requesters.
- Arbitrates round-robin, latches operands and drives the cell inputs and enable.
- Combines the three registered partial products into the low 32 bits of the 32x32 product.
- Returns the result on a single response channel tagged with the requester ID.
- Sits between custom-instruction/accelerator masters and one shared multiplier cell instance.

Parameters:
- CELL_LAT, 1, cycles cell_en must be held high before cell_p1..p3 are valid (cell register depth); legal 1..4.
- W, 32, operand/result width; fixed 32 (16-bit half-split assumed).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has operands
- req0_ready  out  1  requester 0 accepted this cycle
- req0_a  in  32  requester 0 operand A
- req0_b  in  32  requester 0 operand B
- req1_valid, req1_ready, req1_a, req1_b  same as requester 0, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  32  (A*B) mod 2^32
- rsp_id  out  1  index of requester that issued the operation
- cell_src1  out  32  to cell E_src1
- cell_src2  out  32  to cell E_src2
- cell_en  out  1  to cell M_en
- cell_p1  in  32  A[15:0]*B[15:0]
- cell_p2  in  32  A[15:0]*B[31:16]
- cell_p3  in  32  A[31:16]*B[15:0]
- busy  out  1  state != IDLE

Behaviour:
- Clock is clk. Reset is reset_n, asynchronous, active-low. All registers clear on reset_n low regardless of clock.
- Reset values:
  - rsp_valid=0, rsp_data=0, rsp_id=0, cell_en=0, cell_src1=0, cell_src2=0.
  - busy=0, rr_ptr=0, state=IDLE, lat_cnt=0.
- States: IDLE, MUL, SUM, RESP.
- IDLE:
  - grant = rr_ptr when both valids are high; otherwise whichever single valid is high.
  - reqN_ready = (state==IDLE) && grant==N. Combinational; never both high.
  - On accept: latch a/b into cell_src1/cell_src2 and the ID; set rr_ptr = ~granted ID; go to MUL.
- MUL:
  - cell_en=1 for exactly CELL_LAT cycles, counted by lat_cnt.
  - Then go to SUM with cell_en=0. Operands stay stable throughout MUL.
- SUM:
  - Register rsp_data = cell_p1 + ((cell_p2 + cell_p3) << 16), truncated to 32 bits. Carries above bit 31 are discarded.
  - Set rsp_valid=1; go to RESP.
- RESP:
  - rsp_valid, rsp_data and rsp_id are held stable until rsp_valid && rsp_ready.
  - On that handshake: rsp_valid=0, go to IDLE. The next accept is possible the following cycle.
- Latency: accept edge to rsp_valid high = CELL_LAT+2 cycles, i.e. 3 at default. Minimum issue interval = CELL_LAT+3 cycles.
- cell_en is 0 in all states except MUL, so the cell's registered products are frozen while stalled.
- A requester dropping valid before it is granted is legal; nothing is recorded for it.
- req_a/req_b are sampled only on the accept cycle.
- Reset mid-operation:
  - The operation is abandoned; no response is issued.
  - Arbitration restarts with requester 0 priority.
  - The cell's own aclr clears on the same reset.
- rsp_ready is ignored outside RESP.

Decomposition:
- Shared package holds:
  - state enum, 2-bit: IDLE=0, MUL=1, SUM=2, RESP=3;
  - half-word width constant HW=16;
  - function combine_pp(p1,p2,p3) returning the 32-bit sum.
- One natural sub-module: mult_cell_rr_arb, the 2-way round-robin arbiter with rr_ptr update on grant.
- The multiplier cell itself is instantiated at the level above, not inside this block.

Test Plan:
- req0 a=0x00012345, b=0x00010001, rsp_ready=1 -> cell_en high 1 cycle; rsp_valid exactly 3 cycles after accept; rsp_data=0x23462345, rsp_id=0.
- req1 a=0xFFFFFFFF, b=0xFFFFFFFF -> rsp_data=0x00000001, rsp_id=1 (partial-product carry wrap).
- Both valid out of reset: req0 a=7,b=6; req1 a=3,b=5 -> req0 granted first, rsp 0x2A id 0; then req1, rsp 0x0F id 1; then rr_ptr=0. Repeat with only req1 valid -> req1 granted immediately.
- req0 a=2,b=3 with rsp_ready low 5 cycles after rsp_valid -> rsp_data=6 held stable; both reqN_ready=0; cell_en=0 throughout stall. Accept occurs the cycle after the handshake.
- reset_n pulsed low during SUM -> rsp_valid, cell_en and busy go 0 asynchronously; no response after release; the next simultaneous request grants req0.
- CELL_LAT=3 build, a=0x10000, b=0x10000 -> cell_en high 3 cycles; rsp_data=0x00000000; latency 5.
